// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and receiver.
// Frame states, parity modes and the default oversampling rate.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int OVERSAMPLE_DEF = 16;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake into the UART transmitter.
// The producer is the master; the transmitter is the slave.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);

    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Oversampling tick counter marking the end of each serial bit.
// A clear holds the count at zero and ignores a coincident tick.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic baud_tick,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = cnt_w(OVERSAMPLE);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Advance on ticks, wrap at the last tick of the bit.
    always_comb begin
        bit_end = baud_tick && (cnt_q == LAST);
        cnt_d   = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (baud_tick) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-byte holding register feeding an LSB-first
// shifter framed with start, optional parity and 1 or 2 stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int PARITY     = PAR_NONE,
    parameter int STOP_BITS  = 1
) (
    input  logic     clk,
    input  logic     areset,
    input  logic     baud_tick,
    uart_tx_if.slave in_if,
    output logic     tx,
    output logic     busy,
    output logic     done
);

    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);
    localparam logic       HAS_PAR  = (PARITY != PAR_NONE);
    localparam logic       ODD      = (PARITY == PAR_ODD);
    localparam logic       TWO_STOP = (STOP_BITS == 2);

    uart_state_e state_q, state_d;

    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_valid_q, hold_valid_d;
    logic [2:0]           bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;

    logic hs;
    logic load;
    logic last_stop;
    logic timer_clr;
    logic bit_end;

    uart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_timer (
        .clk       (clk),
        .rst       (areset),
        .baud_tick (baud_tick),
        .clear     (timer_clr),
        .bit_end   (bit_end)
    );

    assign in_if.in_ready = ~hold_valid_q;
    assign tx             = tx_q;
    assign busy           = busy_q;

    assign hs        = in_if.in_valid & ~hold_valid_q;
    assign last_stop = ~TWO_STOP | stop_q;

    // Frame sequencing, holding register and next line level.
    // done is raised during the cycle whose tick closes the last
    // stop bit, so it overlaps the final high cycle of the frame.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        bit_d        = bit_q;
        stop_d       = stop_q;
        par_d        = par_q;
        load         = 1'b0;
        timer_clr    = 1'b0;
        done         = 1'b0;

        unique case (state_q)
            IDLE: begin
                timer_clr = 1'b1;
                if (hold_valid_q) begin
                    load    = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    par_d   = par_q ^ shift_q[0];
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        stop_d  = 1'b0;
                        state_d = HAS_PAR ? PAR : STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    stop_d  = 1'b0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (last_stop) begin
                        done = 1'b1;
                        if (hold_valid_q) begin
                            load      = 1'b1;
                            timer_clr = 1'b1;
                            state_d   = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Shifter takes the held byte; parity restarts per frame.
        if (load) begin
            shift_d      = hold_q;
            par_d        = 1'b0;
            bit_d        = '0;
            stop_d       = 1'b0;
            hold_valid_d = 1'b0;
        end

        // A new byte lands after the unload so it is never lost.
        if (hs) begin
            hold_d       = in_if.in_data;
            hold_valid_d = 1'b1;
        end
    end

    // Line level and busy follow the state being entered.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PAR:     tx_d = par_d ^ ODD;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            bit_q        <= '0;
            stop_q       <= 1'b0;
            par_q        <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            bit_q        <= bit_d;
            stop_q       <= stop_d;
            par_q        <= par_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameterisations side by side, a frame
// model built from tick counts, vector table and corner sequences.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int OS   = 16;
    localparam int NDUT = 4;

    logic clk = 1'b0;
    logic areset;
    logic baud_tick;

    logic [7:0] in_data  [NDUT];
    logic       in_valid [NDUT];
    logic       in_ready [NDUT];
    logic       tx       [NDUT];
    logic       busy     [NDUT];
    logic       done     [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int P = (g == 1) ? PAR_EVEN :
                           ((g == 2) ? PAR_ODD : PAR_NONE);
        localparam int S = (g == 3) ? 2 : 1;

        uart_tx_if #(.DATA_BITS(8)) bus ();

        assign bus.in_data  = in_data[g];
        assign bus.in_valid = in_valid[g];
        assign in_ready[g]  = bus.in_ready;

        uart_tx #(
            .DATA_BITS (8),
            .OVERSAMPLE(OS),
            .PARITY    (P),
            .STOP_BITS (S)
        ) u_dut (
            .clk      (clk),
            .areset   (areset),
            .baud_tick(baud_tick),
            .in_if    (bus),
            .tx       (tx[g]),
            .busy     (busy[g]),
            .done     (done[g])
        );
    end

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int k,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0h want %0h @%0t",
                     name, k, act, exp, $time);
        end
    endtask

    function automatic int par_of(input int k);
        return (k == 1) ? 1 : ((k == 2) ? 2 : 0);
    endfunction

    function automatic int stop_of(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    // Line level per bit slot: slot 0 start, data LSB first, parity,
    // then stop slots left high.
    function automatic logic [11:0] frame_bits(input logic [7:0] d,
                                               input int par,
                                               input int stops,
                                               output int len);
        logic [11:0] b;
        b      = '1;
        b[0]   = 1'b0;
        b[8:1] = d;
        len    = 9 + stops;
        if (par != 0) begin
            b[9] = (^d) ^ (par == 2);
            len++;
        end
        return b;
    endfunction

    // Reference model: a frame is active for len*OS counted ticks.
    bit          m_act   [NDUT];
    bit          m_hfull [NDUT];
    int          m_ticks [NDUT];
    int          m_len   [NDUT];
    logic [7:0]  m_hold  [NDUT];
    logic [11:0] m_bits  [NDUT];

    task automatic m_start(input int k);
        m_bits[k]  = frame_bits(m_hold[k], par_of(k), stop_of(k),
                                m_len[k]);
        m_act[k]   = 1'b1;
        m_ticks[k] = 0;
        m_hfull[k] = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge areset);
            for (int k = 0; k < NDUT; k++) begin
                if (areset) begin
                    m_act[k]   = 1'b0;
                    m_hfull[k] = 1'b0;
                    m_ticks[k] = 0;
                end else begin
                    bit rdy;
                    rdy = !m_hfull[k];
                    if (m_act[k]) begin
                        if (baud_tick) m_ticks[k]++;
                        if (m_ticks[k] == m_len[k] * OS) begin
                            if (m_hfull[k]) m_start(k);
                            else m_act[k] = 1'b0;
                        end
                    end else if (m_hfull[k]) begin
                        m_start(k);
                    end
                    if (in_valid[k] && rdy) begin
                        m_hfull[k] = 1'b1;
                        m_hold[k]  = in_data[k];
                    end
                end
            end
        end
    end

    bit chk_en = 1'b0;
    int done_cnt [NDUT];

    // Cycle compare against the model, away from the active edge.
    initial begin
        for (int k = 0; k < NDUT; k++) done_cnt[k] = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                logic e_tx, e_dn;
                if (done[k] === 1'b1) done_cnt[k]++;
                if (chk_en) begin
                    e_tx = m_act[k] ? m_bits[k][m_ticks[k] / OS] : 1'b1;
                    e_dn = m_act[k] && baud_tick &&
                           (m_ticks[k] == m_len[k] * OS - 1);
                    check("m_tx", k, 32'(tx[k]), 32'(e_tx));
                    check("m_busy", k, 32'(busy[k]), 32'(m_act[k]));
                    check("m_ready", k, 32'(in_ready[k]),
                          32'(!m_hfull[k]));
                    check("m_done", k, 32'(done[k]), 32'(e_dn));
                end
            end
        end
    end

    // Baud strobe: 0 = always high, <0 = random, N = every Nth clk.
    int baud_mode = 0;
    int cyc = 0;

    initial begin
        baud_tick = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (baud_mode == 0) baud_tick = 1'b1;
            else if (baud_mode < 0) baud_tick = ($urandom_range(0, 3) != 0);
            else baud_tick = ((cyc % baud_mode) == 0);
        end
    end

    typedef struct {
        int          k;
        logic [7:0]  data;
        int          period;
        int          exp_ticks;
        logic [11:0] exp_bits;
    } vec_t;

    vec_t vt [7];

    task automatic wait_idle(input int k);
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (!busy[k] && in_ready[k]) return;
        end
        check("idle_timeout", k, 0, 1);
    endtask

    task automatic run_vec(input vec_t v);
        int  ticks;
        bit  seen;
        logic bt;
        wait_idle(v.k);
        baud_mode = v.period;
        @(posedge clk);
        #1;
        in_valid[v.k] = 1'b1;
        in_data[v.k]  = v.data;
        @(posedge clk);
        #1;
        in_valid[v.k] = 1'b0;
        in_data[v.k]  = 8'($urandom);
        @(negedge clk);
        check("lat_ready_lo", v.k, 32'(in_ready[v.k]), 0);
        check("lat_tx_high", v.k, 32'(tx[v.k]), 1);
        @(negedge clk);
        check("lat_tx_fall", v.k, 32'(tx[v.k]), 0);
        check("lat_ready_hi", v.k, 32'(in_ready[v.k]), 1);
        ticks = 0;
        seen  = 1'b0;
        for (int c = 0; c < 5000 && !seen; c++) begin
            @(posedge clk);
            bt = baud_tick;
            if (bt) ticks++;
            @(negedge clk);
            if (bt && (ticks % OS) == OS / 2)
                check("vec_slot", v.k, 32'(tx[v.k]),
                      32'(v.exp_bits[ticks / OS]));
            if (done[v.k]) begin
                seen = 1'b1;
                check("vec_len", v.k, ticks + 1, v.exp_ticks);
            end
        end
        if (!seen) check("vec_done_timeout", v.k, 0, 1);
        @(negedge clk);
        check("vec_end_busy", v.k, 32'(busy[v.k]), 0);
        check("vec_end_done", v.k, 32'(done[v.k]), 0);
        check("vec_end_tx", v.k, 32'(tx[v.k]), 1);
        baud_mode = 0;
    endtask

    initial begin
        logic q_tx [$];
        int   dq [$];
        int   runs [$];
        int   d0, highs, rl;
        logic cur;
        bit   got2;

        areset = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            in_valid[k] = 1'b0;
            in_data[k]  = '0;
        end

        vt[0] = '{0, 8'hA5, 1, 160, {3'b111, 8'hA5, 1'b0}};
        vt[1] = '{0, 8'h3C, 4, 160, {3'b111, 8'h3C, 1'b0}};
        vt[2] = '{1, 8'h07, 1, 176, {2'b11, 1'b1, 8'h07, 1'b0}};
        vt[3] = '{2, 8'h07, 1, 176, {2'b11, 1'b0, 8'h07, 1'b0}};
        vt[4] = '{3, 8'hFF, 1, 176, {3'b111, 8'hFF, 1'b0}};
        vt[5] = '{1, 8'h00, 1, 176, {2'b11, 1'b0, 8'h00, 1'b0}};
        vt[6] = '{2, 8'hA5, 2, 176, {2'b11, 1'b1, 8'hA5, 1'b0}};

        repeat (2) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check("rst_tx", k, 32'(tx[k]), 1);
            check("rst_busy", k, 32'(busy[k]), 0);
            check("rst_ready", k, 32'(in_ready[k]), 1);
            check("rst_done", k, 32'(done[k]), 0);
        end
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        areset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // Back-to-back 0x00 then 0xFF with in_valid held.
        wait_idle(0);
        got2 = 1'b0;
        fork
            begin
                @(posedge clk);
                #1;
                in_valid[0] = 1'b1;
                in_data[0]  = 8'h00;
                @(posedge clk);
                #1;
                in_data[0] = 8'hFF;
                for (int c = 0; c < 50 && !got2; c++) begin
                    @(negedge clk);
                    if (in_ready[0]) begin
                        check("b2b_busy_hs2", 0, 32'(busy[0]), 1);
                        @(posedge clk);
                        #1;
                        in_valid[0] = 1'b0;
                        got2 = 1'b1;
                    end
                end
                if (!got2) begin
                    check("b2b_hs2_timeout", 0, 0, 1);
                    in_valid[0] = 1'b0;
                end
            end
            begin
                for (int c = 0; c < 420; c++) begin
                    @(negedge clk);
                    q_tx.push_back(tx[0]);
                    if (done[0]) dq.push_back(c);
                end
            end
        join
        check("b2b_ndone", 0, dq.size(), 2);
        if (dq.size() == 2) check("b2b_gap", 0, dq[1] - dq[0], 160);
        cur = q_tx[0];
        rl  = 1;
        for (int i = 1; i < q_tx.size(); i++) begin
            if (q_tx[i] == cur) rl++;
            else begin
                runs.push_back(rl);
                cur = q_tx[i];
                rl  = 1;
            end
        end
        runs.push_back(rl);
        if (runs.size() < 5) check("b2b_runs", 0, runs.size(), 5);
        else begin
            check("b2b_low1", 0, runs[1], 144);
            check("b2b_stop", 0, runs[2], 16);
            check("b2b_start2", 0, runs[3], 16);
        end

        // Reset in DATA bit 3 of 0x55 with a byte held.
        wait_idle(0);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h55;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (m_act[0] && m_ticks[0] >= 4 * OS + 4) break;
        end
        @(posedge clk);
        #1;
        in_valid[0] = 1'b1;
        in_data[0]  = 8'($urandom);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(negedge clk);
        check("rs_hold_full", 0, 32'(in_ready[0]), 0);
        check("rs_in_data", 0, 32'(busy[0]), 1);
        d0 = done_cnt[0];
        #2;
        areset = 1'b1;
        #1;
        check("rs_tx", 0, 32'(tx[0]), 1);
        check("rs_busy", 0, 32'(busy[0]), 0);
        check("rs_ready", 0, 32'(in_ready[0]), 1);
        check("rs_done", 0, 32'(done[0]), 0);
        repeat (3) @(posedge clk);
        #1;
        areset = 1'b0;
        highs = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (tx[0] && !busy[0]) highs++;
        end
        check("rs_quiet", 0, highs, 300);
        check("rs_no_done", 0, done_cnt[0], d0);

        // Random traffic on all four with a random baud strobe.
        baud_mode = -1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NDUT; k++) begin
                in_valid[k] = ($urandom_range(0, 3) == 0);
                in_data[k]  = 8'($urandom);
            end
        end
        for (int k = 0; k < NDUT; k++) in_valid[k] = 1'b0;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: accepts parallel bytes on a valid/ready handshake and drives LSB-first frames on `tx`. Format is 1 start bit, DATA_BITS data bits, optional parity, and 1 or 2 stop bits. Bit timing comes from the shared 16x oversampling `baud_tick` strobe, so each bit lasts exactly OVERSAMPLE ticks. A one-entry holding register allows back-to-back frames with no idle gap. The block is the transmit counterpart of the UART receiver and shares its baud generator and frame format.

## Interface
- DATA_BITS, 8, data bits per frame (5..8)
- OVERSAMPLE, 16, baud_tick pulses per bit (must match receiver)
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, stop bits per frame (1 or 2)

- clk  input  1  sole clock, all logic on posedge
- areset  input  1  asynchronous, active-high reset
- baud_tick  input  1  single-cycle oversampling strobe; held high = one tick per clk
- in_data  input  DATA_BITS  byte to send, sampled on handshake
- in_valid  input  1  in_data valid
- in_ready  output  1  holding register empty; transfer when in_valid & in_ready
- tx  output  1  serial line, registered, idle high
- busy  output  1  frame in progress (state != IDLE)
- done  output  1  one-cycle pulse at end of last stop bit

## Operation
- States: IDLE, START, DATA, PAR, STOP.
- Holding register `hold`/`hold_valid`:
  - Loaded on handshake.
  - `in_ready = ~hold_valid`.
  - Load and unload in the same cycle: the new byte is kept, the old byte goes to the shifter.
- IDLE:
  - `tx=1`.
  - If `hold_valid`: move `hold` to the shift register, clear `hold_valid`, go to START, and clear the tick and bit counters.
- START: `tx=0`. After OVERSAMPLE ticks, go to DATA.
- DATA: `tx=shift[0]`. Every OVERSAMPLE ticks, shift right and increment the bit counter. After DATA_BITS bits, go to PAR if PARITY != 0, else STOP.
- PAR:
  - `tx` = XOR of the frame's data bits (even), or its inverse (odd).
  - Parity is accumulated while shifting.
  - Lasts OVERSAMPLE ticks, then go to STOP.
- STOP:
  - `tx=1` for STOP_BITS×OVERSAMPLE ticks.
  - At the end: pulse `done`.
  - If `hold_valid`, go directly to START, loading the shifter that cycle. Otherwise go to IDLE.
- Tick counter:
  - 4 bits (width = clog2(OVERSAMPLE)).
  - Increments only on `baud_tick`.
  - A bit ends on the clk where the counter is OVERSAMPLE-1 and `baud_tick` is high; the counter wraps to 0 there.
- Bit counter: 3 bits, wraps to 0 when leaving DATA.
- in_data is captured on handshake. Changes to in_data after the handshake do not affect the frame.

## Timing
- Reset values: `tx=1`, `in_ready=1`, `busy=0`, `done=0`, `hold_valid=0`, state IDLE, all counters 0.
- Reset during a frame aborts it immediately (async): `tx` returns high and any held byte is discarded. No `done` is produced.
- Latency: handshake at edge N, then `tx` falls at edge N+2 (N+1 loads `hold`, N+2 leaves IDLE with the registered `tx`).
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) × OVERSAMPLE ticks. With `baud_tick` constantly high, 8N1 is 160 clks.
- Back-to-back: with `hold_valid` set before the last stop bit ends, the next start bit begins on the clk after `done`. There is no idle high beyond the stop bit(s).
- `in_ready` deasserts the cycle after a handshake. It reasserts the cycle after `hold` moves to the shifter.
- `baud_tick` arriving in the same cycle as leaving IDLE is not counted. Counting starts in START.
- `done` coincides with the final `tx=1` cycle. `busy` drops the cycle after `done`, unless a new frame starts.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE/START/DATA/PAR/STOP, also reused by the receiver's 2-bit subset)
  - parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD
  - OVERSAMPLE default
- One natural sub-module, `uart_bit_timer`:
  - tick counter with clear input
  - `bit_end` output when count == OVERSAMPLE-1 and `baud_tick` is high
  - reusable by the receiver

## Test plan
- 8N1, `baud_tick` always high, send 0xA5:
  - `tx` = 0, then 1,0,1,0,0,1,0,1, then 1; each level 16 clks.
  - `done` pulses at 160 clks after the start bit falls.
- `baud_tick` every 4th clk, send 0x3C: every bit lasts exactly 64 clks, and bits 2..5 are high.
- PARITY=1 (even), send 0x07: parity bit = 1. With PARITY=2 (odd): parity bit = 0. Frame length is 176 clks.
- Back-to-back 0x00 then 0xFF, with `in_valid` held high:
  - second handshake happens while busy
  - `tx` goes stop bit (16 high), then start bit (16 low) with no extra idle
  - two `done` pulses, 160 clks apart
  - `in_ready` is low while the hold is full
- Reset mid-DATA (bit 3 of 0x55), with a held byte pending:
  - `tx=1` immediately
  - `busy=0`, `in_ready=1`, no `done`
  - no frame after reset releases until a new handshake
- STOP_BITS=2, send 0xFF: `tx` is high for 32 clks after the data bits, then `done` pulses.
